// File: rtl/p1_sprite_renderer_pkg.sv
// Shared constants, types and helpers for the player-1 sprite renderer.
package p1_sprite_renderer_pkg;

    localparam int unsigned DEF_SPRITE_W = 128;
    localparam int unsigned DEF_SPRITE_H = 128;
    localparam int unsigned POS_W        = 10;
    localparam int unsigned EXT_W        = POS_W + 1;
    localparam int unsigned COL_W        = 7;
    localparam int unsigned ROW_W        = 7;
    localparam int unsigned ADDR_W       = 14;
    localparam int unsigned RGB_W        = 12;

    localparam logic [1:0] FRAME_IDLE  = 2'd0;
    localparam logic [1:0] FRAME_WALK1 = 2'd1;
    localparam logic [1:0] FRAME_WALK2 = 2'd2;

    typedef struct packed {
        logic von;
        logic in_box;
    } qual_t;

    // One extra bit keeps base+len from wrapping when the box hangs off the edge.
    function automatic logic in_span(input logic [POS_W-1:0] pos,
                                     input logic [POS_W-1:0] base,
                                     input int unsigned      len);
        logic [EXT_W-1:0] p;
        logic [EXT_W-1:0] b;
        logic [EXT_W-1:0] e;
        p = {1'b0, pos};
        b = {1'b0, base};
        e = b + EXT_W'(len);
        return (p >= b) && (p < e);
    endfunction

endpackage

// File: rtl/p1_sprite_renderer_if.sv
// Pixel, geometry and ROM signals between the VGA front end, the ROMs and the renderer.
interface p1_sprite_renderer_if;
    import p1_sprite_renderer_pkg::*;

    logic [POS_W-1:0]  hcount;
    logic [POS_W-1:0]  vcount;
    logic              video_on;
    logic              frame_tick;
    logic [POS_W-1:0]  sprite_x;
    logic [POS_W-1:0]  sprite_y;
    logic              facing_left;
    logic              walking;
    logic [ADDR_W-1:0] rom_addr;
    logic [1:0]        frame_sel;
    logic [RGB_W-1:0]  rom_pixel;
    logic [RGB_W-1:0]  pixel_rgb;
    logic              pixel_hit;

    modport master (
        output hcount, vcount, video_on, frame_tick, sprite_x, sprite_y,
        output facing_left, walking, rom_pixel,
        input  rom_addr, frame_sel, pixel_rgb, pixel_hit
    );

    modport slave (
        input  hcount, vcount, video_on, frame_tick, sprite_x, sprite_y,
        input  facing_left, walking, rom_pixel,
        output rom_addr, frame_sel, pixel_rgb, pixel_hit
    );

endinterface

// File: rtl/p1_anim_fsm.sv
// Idle/walk animation sequencer; advances only on frame_tick.
module p1_anim_fsm
    import p1_sprite_renderer_pkg::*;
#(
    parameter int unsigned ANIM_DIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       walking,
    output logic [1:0] frame_sel
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WALK1 = 2'd1;
    localparam logic [1:0] ST_WALK2 = 2'd2;

    localparam int unsigned     CNT_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_DIV - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_frame_sel;
    logic [1:0]       w_frame_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (frame_tick) begin
            if (!walking) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end else if (r_state == ST_IDLE) begin
                w_state_nxt = ST_WALK1;
                w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
                w_state_nxt = (r_state == ST_WALK1) ? ST_WALK2 : ST_WALK1;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_frame_nxt = FRAME_IDLE;
        case (w_state_nxt)
            ST_WALK1: w_frame_nxt = FRAME_WALK1;
            ST_WALK2: w_frame_nxt = FRAME_WALK2;
            default:  w_frame_nxt = FRAME_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_frame_sel <= FRAME_IDLE;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_frame_sel <= w_frame_nxt;
        end
    end

    assign frame_sel = r_frame_sel;

endmodule

// File: rtl/p1_sprite_renderer.sv
// Player-1 sprite address generator and colour-keyed compositor; 3-clk pixel pipeline.
module p1_sprite_renderer
    import p1_sprite_renderer_pkg::*;
#(
    parameter int unsigned      SPRITE_W    = DEF_SPRITE_W,
    parameter int unsigned      SPRITE_H    = DEF_SPRITE_H,
    parameter int unsigned      ANIM_DIV    = 8,
    parameter logic [RGB_W-1:0] TRANSPARENT = 12'hF0F
) (
    input  logic                 clk,
    input  logic                 reset,
    p1_sprite_renderer_if.slave  bus
);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(SPRITE_W - 1);

    logic [POS_W-1:0]  r_x_lat;
    logic [POS_W-1:0]  r_y_lat;
    logic              r_facing;
    logic [ADDR_W-1:0] r_rom_addr;
    qual_t             r_q1;
    qual_t             r_q2;
    logic [RGB_W-1:0]  r_rgb;
    logic              r_hit;

    logic [COL_W-1:0]  w_dx;
    logic [ROW_W-1:0]  w_dy;
    logic [COL_W-1:0]  w_col;
    logic              w_in_box;
    logic [ADDR_W-1:0] w_addr;
    qual_t             w_q0;
    logic [1:0]        w_frame_sel;

    // Only the low bits of the offset matter inside the box, so they are taken directly.
    assign w_dx     = bus.hcount[COL_W-1:0] - r_x_lat[COL_W-1:0];
    assign w_dy     = bus.vcount[ROW_W-1:0] - r_y_lat[ROW_W-1:0];
    assign w_col    = r_facing ? (COL_MAX - w_dx) : w_dx;
    assign w_in_box = in_span(bus.hcount, r_x_lat, SPRITE_W) &&
                      in_span(bus.vcount, r_y_lat, SPRITE_H);
    assign w_addr   = w_in_box ? {w_dy, w_col} : '0;
    assign w_q0     = '{von: bus.video_on, in_box: w_in_box};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x_lat    <= '0;
            r_y_lat    <= '0;
            r_facing   <= 1'b0;
            r_rom_addr <= '0;
            r_q1       <= '0;
            r_q2       <= '0;
            r_rgb      <= '0;
            r_hit      <= 1'b0;
        end else begin
            if (bus.frame_tick) begin
                r_x_lat  <= bus.sprite_x;
                r_y_lat  <= bus.sprite_y;
                r_facing <= bus.facing_left;
            end
            r_rom_addr <= w_addr;
            r_q1       <= w_q0;
            r_q2       <= r_q1;
            if (r_q2.von && r_q2.in_box && (bus.rom_pixel != TRANSPARENT)) begin
                r_rgb <= bus.rom_pixel;
                r_hit <= 1'b1;
            end else begin
                r_rgb <= '0;
                r_hit <= 1'b0;
            end
        end
    end

    p1_anim_fsm #(
        .ANIM_DIV (ANIM_DIV)
    ) u_anim_fsm (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (bus.frame_tick),
        .walking    (bus.walking),
        .frame_sel  (w_frame_sel)
    );

    assign bus.rom_addr  = r_rom_addr;
    assign bus.frame_sel = w_frame_sel;
    assign bus.pixel_rgb = r_rgb;
    assign bus.pixel_hit = r_hit;

endmodule

// File: tb/tb_p1_sprite_renderer.sv
// Directed bench for p1_sprite_renderer with a queue-based scoreboard and a sync ROM model.
module tb_p1_sprite_renderer;
    import p1_sprite_renderer_pkg::*;

    typedef struct {
        int          due;
        logic [13:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   g_fsel = 0;
    exp_t q_addr[$];
    exp_t q_pix[$];
    exp_t q_fsel[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    p1_sprite_renderer_if bus();

    p1_sprite_renderer #(
        .SPRITE_W    (128),
        .SPRITE_H    (128),
        .ANIM_DIV    (8),
        .TRANSPARENT (12'hF0F)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous ROM: colour key at address 5, solid colour elsewhere.
    always @(posedge clk) bus.rom_pixel <= (bus.rom_addr == 14'd5) ? 12'hF0F : 12'hABC;

    task automatic cmp(input string nm, input logic [13:0] act, input logic [13:0] exp_v);
        n_cmp = n_cmp + 1;
        if (act !== exp_v) begin
            n_bad = n_bad + 1;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q_addr.size() != 0 && q_addr[0].due <= cyc) begin
            e = q_addr.pop_front();
            cmp("rom_addr", bus.rom_addr, e.val);
        end
        while (q_pix.size() != 0 && q_pix[0].due <= cyc) begin
            e = q_pix.pop_front();
            cmp("pixel_hit_rgb", {1'b0, bus.pixel_hit, bus.pixel_rgb}, e.val);
        end
        while (q_fsel.size() != 0 && q_fsel[0].due <= cyc) begin
            e = q_fsel.pop_front();
            cmp("frame_sel", {12'd0, bus.frame_sel}, e.val);
        end
    end

    // One cycle of stimulus plus the expected responses it should produce.
    task automatic drive(input int h, input int v, input bit von, input bit rst, input bit tick,
                         input bit ca, input int ea, input bit cp, input bit eh, input int er);
        reset          = rst;
        bus.hcount     = 10'(h);
        bus.vcount     = 10'(v);
        bus.video_on   = von;
        bus.frame_tick = tick;
        if (rst) g_fsel = 0;
        if (ca) q_addr.push_back('{cyc + 1, 14'(ea)});
        if (cp) q_pix.push_back('{cyc + 3, {1'b0, eh, 12'(er)}});
        q_fsel.push_back('{cyc + 1, 14'(g_fsel)});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 500, 0, 0, 0, 1, 0, 1, 0, 0);
    endtask

    task automatic tick(input int x, input int y, input bit f, input bit w, input int efs);
        bus.sprite_x    = 10'(x);
        bus.sprite_y    = 10'(y);
        bus.facing_left = f;
        bus.walking     = w;
        g_fsel          = efs;
        drive(0, 500, 0, 0, 1, 1, 0, 1, 0, 0);
    endtask

    initial begin
        int  c;
        bit  in;
        reset = 1'b1;
        bus.hcount = '0; bus.vcount = '0; bus.video_on = 1'b0; bus.frame_tick = 1'b0;
        bus.sprite_x = '0; bus.sprite_y = '0; bus.facing_left = 1'b0; bus.walking = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        repeat (3) drive(300, 300, 1, 1, 0, 1, 0, 1, 0, 0);

        // Corner addresses, unmirrored
        tick(100, 50, 0, 0, 0);
        drive(100, 50, 1, 0, 0, 1, 0, 1, 1, 'hABC);
        drive(227, 177, 1, 0, 0, 1, 16383, 1, 1, 'hABC);
        drive(228, 177, 1, 0, 0, 1, 0, 1, 0, 0);
        drive(227, 178, 1, 0, 0, 1, 0, 1, 0, 0);
        drive(99, 50, 1, 0, 0, 1, 0, 1, 0, 0);
        drive(110, 60, 0, 0, 0, 1, 1290, 1, 0, 0);
        drive(105, 50, 1, 0, 0, 1, 5, 1, 0, 0);

        // Mirrored
        tick(100, 50, 1, 0, 0);
        drive(100, 50, 1, 0, 0, 1, 127, 1, 1, 'hABC);
        drive(227, 50, 1, 0, 0, 1, 0, 1, 1, 'hABC);
        drive(222, 50, 1, 0, 0, 1, 5, 1, 0, 0);
        drive(100, 51, 1, 0, 0, 1, 255, 1, 1, 'hABC);

        // First-row scan, key pixel at column 5
        tick(100, 50, 0, 0, 0);
        for (int h = 98; h <= 230; h++) begin
            in = (h >= 100) && (h <= 227);
            c  = h - 100;
            drive(h, 50, 1, 0, 0, 1, in ? c : 0, 1, in && (c != 5), (in && c != 5) ? 'hABC : 0);
        end

        // Bottom rows near screen edge
        tick(100, 400, 0, 0, 0);
        drive(101, 479, 1, 0, 0, 1, 10113, 1, 1, 'hABC);

        // Animation sequence
        for (int i = 1; i <= 17; i++) begin
            tick(100, 50, 0, 1, (i <= 8) ? 1 : ((i <= 16) ? 2 : 1));
            idle();
        end
        tick(100, 50, 0, 0, 0);
        bus.walking = 1'b1;
        idle();
        idle();

        // Right-edge overhang: no wrap to column 0
        tick(600, 50, 0, 0, 0);
        for (int h = 600; h <= 639; h++) begin
            c = h - 600;
            drive(h, 50, 1, 0, 0, 1, c, 1, c != 5, (c != 5) ? 'hABC : 0);
        end
        for (int h = 0; h <= 39; h++) drive(h, 50, 1, 0, 0, 1, 0, 1, 0, 0);
        bus.sprite_x    = 10'd0;
        bus.facing_left = 1'b1;
        for (int h = 0; h <= 3; h++) drive(h, 50, 1, 0, 0, 1, 0, 1, 0, 0);
        drive(610, 50, 1, 0, 0, 1, 10, 1, 1, 'hABC);
        drive(601, 50, 1, 0, 0, 1, 1, 1, 1, 'hABC);

        // Latched x above 512: 11-bit compare must not wrap
        tick(1000, 50, 0, 0, 0);
        drive(0, 50, 1, 0, 0, 1, 0, 1, 0, 0);
        drive(50, 50, 1, 0, 0, 1, 0, 1, 0, 0);
        drive(1023, 50, 1, 0, 0, 1, 23, 1, 1, 'hABC);

        // Reset mid-span while walking
        tick(100, 50, 0, 1, 1);
        idle();
        drive(100, 50, 1, 0, 0, 1, 0, 1, 1, 'hABC);
        drive(101, 50, 1, 0, 0, 1, 1, 1, 1, 'hABC);
        drive(102, 50, 1, 0, 0, 1, 2, 1, 1, 'hABC);
        drive(103, 50, 1, 0, 0, 1, 3, 1, 0, 0);
        drive(104, 50, 1, 0, 0, 1, 4, 1, 0, 0);
        drive(105, 50, 1, 1, 0, 1, 0, 1, 0, 0);
        drive(101, 50, 1, 0, 0, 1, 6501, 1, 1, 'hABC);
        drive(5, 0, 1, 0, 0, 1, 5, 1, 0, 0);
        idle();

        repeat (4) drive(0, 500, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && (q_addr.size() + q_pix.size() + q_fsel.size()) != 0; i++)
            @(posedge clk);
        if ((q_addr.size() + q_pix.size() + q_fsel.size()) != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL drain: %0d expected responses never compared, required 0",
                     q_addr.size() + q_pix.size() + q_fsel.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
